vga_timing: RTL and testbench
=============================

# vga_timing

Pixel timing generator for the 1440x900 @ 60 Hz display path. It produces the raw pixel coordinates `pos_x`/`pos_y` and the 6-bit frame counter `count` that the screen renderers consume (title, play field, ending). It also produces `hsync`/`vsync`/`active`, delayed so that they line up with the renderers' registered RGB output. It sits between the pixel clock source and the renderer/colour mux at the top level.

## Interface
Parameters:
- `H_ACTIVE`, 1440, visible pixels per line
- `H_FP`, 80, horizontal front porch (pixels)
- `H_SYNC`, 152, hsync width (pixels)
- `H_BP`, 232, horizontal back porch; line total is 1904
- `V_ACTIVE`, 900, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vsync width (lines)
- `V_BP`, 28, vertical back porch; frame total is 932
- `H_POL`, 0, hsync asserted level (0 = active-low)
- `V_POL`, 1, vsync asserted level
- `FRAME_WRAP`, 60, modulus of `count`
- `PIPE_DLY`, 1, renderer latency in cycles; legal range 1..4

Ports:
- `clk`  in  1  pixel clock, 106.47 MHz
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `pos_x`  out  11  horizontal counter, 0..1903
- `pos_y`  out  11  vertical counter, 0..931
- `count`  out  6  frame counter, 0..FRAME_WRAP-1
- `line_start`  out  1  one-cycle pulse while `pos_x`==0
- `frame_start`  out  1  one-cycle pulse while `pos_x`==0 and `pos_y`==0
- `active`  out  1  visible-region flag, delayed by PIPE_DLY
- `hsync`  out  1  horizontal sync, delayed by PIPE_DLY
- `vsync`  out  1  vertical sync, delayed by PIPE_DLY

## Operation
- **Horizontal counter.** `pos_x` increments every cycle and wraps from H_TOTAL-1 (1903) to 0.
- **Vertical counter.** `pos_y` increments only on the `pos_x` wrap, and wraps from V_TOTAL-1 (931) to 0.
- **Frame counter.** `count` increments on the cycle where both counters wrap together, so the new value appears when `pos_x`=`pos_y`=0. It wraps FRAME_WRAP-1 → 0 (59 → 0). Renderers use `count <= 30` as the blink phase.
- **Undelayed raw flags**, computed from the current counter values:
  - active_raw = (`pos_x` < H_ACTIVE) && (`pos_y` < V_ACTIVE).
  - hsync_raw is asserted for `pos_x` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [1520, 1672).
  - vsync_raw is asserted for `pos_y` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [901, 904), for whole lines.
- **Polarity.** An asserted sync is driven at H_POL / V_POL; deasserted is the inverse.
- **Delay line.** active_raw, hsync_raw and vsync_raw pass through a PIPE_DLY-deep register chain before reaching the ports.
- **No delay on coordinates.** `pos_x`, `pos_y`, `count`, `line_start` and `frame_start` are not delayed.
- **Widths.** All comparisons are unsigned and 11 bits wide, with no overflow. H_TOTAL and V_TOTAL are ≤ 2047 by construction.

## Timing
- **Reset values** (rst_n low):
  - `pos_x`=0, `pos_y`=0, `count`=0
  - `line_start`=0, `frame_start`=0, `active`=0
  - `hsync`=~H_POL (1), `vsync`=~V_POL (0)
  - every delay-line stage is filled with the deasserted level.
- **Reset release.**
  - The first rising edge after rst_n rises is cycle 0. `pos_x`=0 and `pos_y`=0 are held through it.
  - The first increment happens on the following edge.
  - `line_start` and `frame_start` go high in cycle 0.
- **Registered outputs.** `pos_x`, `pos_y`, `count`, `line_start` and `frame_start` are all registers and change on the same edge.
- **Sync/active alignment.** `active`, `hsync` and `vsync` equal the raw value for the coordinate that was on `pos_x`/`pos_y` PIPE_DLY cycles earlier.
- **Reset mid-frame.** Everything returns to the reset values asynchronously. No partial frame increments `count`.
- **Frame boundary.** At `pos_x`=1903, `pos_y`=931, `count`=59, the next edge produces `pos_x`=0, `pos_y`=0, `count`=0 and `frame_start`=1.

## Structure
- Package `vga_timing_pkg`:
  - 1440x900 default constants for H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, H_POL, V_POL.
  - Derived H_TOTAL and V_TOTAL.
  - Coordinate width constant (11).
- Sub-module `sig_delay` (parameters WIDTH, DEPTH, RST_VAL): an async-reset shift register. It is instantiated once, with WIDTH=3, for active, hsync and vsync.

## Test plan
- **Reset hold.** Hold rst_n low for 10 cycles → `pos_x`=0, `pos_y`=0, `count`=0, `hsync`=1, `vsync`=0, `active`=0. Release → `frame_start`=1 in cycle 0 only.
- **Line timing.** Run one full line:
  - `pos_x` runs 0..1903, then 0.
  - `line_start` is high exactly once per 1904 cycles.
  - With PIPE_DLY=1, `hsync` is low for exactly 152 cycles, starting when `pos_x`=1521.
- **Frame timing.** Run one frame:
  - `vsync` is high for exactly 3×1904 cycles, starting with `pos_y`=901 delayed by one cycle.
  - `active` is high for 900×1440 cycles.
- **Count wrap.** Run 61 frames → `count` goes 0..59, then 0. Every `count` change coincides with `frame_start`=1.
- **Pipeline alignment.** With PIPE_DLY=3, `active` rises 3 cycles after the `pos_x`=0, `pos_y`=0 frame start, and falls 3 cycles after `pos_x`=1440 on each active line.
- **Mid-frame reset.** Pulse rst_n low at `pos_x`=700, `pos_y`=450, `count`=17 → all outputs return to reset values immediately, without waiting for a clock edge. After release, counting restarts from 0/0/0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the 1440x900 @ 60 Hz pixel timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_ACTIVE = 1440;
  localparam int DEF_H_FP     = 80;
  localparam int DEF_H_SYNC   = 152;
  localparam int DEF_H_BP     = 232;
  localparam int DEF_V_ACTIVE = 900;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 28;
  localparam logic DEF_H_POL  = 1'b0;
  localparam logic DEF_V_POL  = 1'b1;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Field order fixes the bit order of the delay-line word.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic logic in_span(input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Async-reset shift register; every stage resets to RST_VAL.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Pixel/line/frame counters plus sync and active flags delayed to match the
// renderers' registered RGB output.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_POL      = DEF_H_POL,
  parameter logic V_POL      = DEF_V_POL,
  parameter int   FRAME_WRAP = 60,
  parameter int   PIPE_DLY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic [5:0]  count,
  output logic        line_start,
  output logic        frame_start,
  output logic        active,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]         CNT_LAST = 6'(FRAME_WRAP - 1);

  // run is low only until the first edge after reset, which holds 0/0
  logic                run;
  logic                x_wrap, y_wrap;
  logic [COORD_W-1:0]  x_next, y_next;
  sync_t               flags_p0, flags_pn;

  always_comb begin
    x_wrap = (pos_x == H_LAST);
    y_wrap = (pos_y == V_LAST);
    x_next = x_wrap ? '0 : pos_x + 1'b1;
    y_next = pos_y;
    if (x_wrap) y_next = y_wrap ? '0 : pos_y + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      count       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!run) begin
      run         <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      pos_x       <= x_next;
      pos_y       <= y_next;
      line_start  <= x_wrap;
      frame_start <= x_wrap && y_wrap;
      if (x_wrap && y_wrap) count <= (count == CNT_LAST) ? '0 : count + 1'b1;
    end
  end

  // Stage p0: raw flags from the current coordinates, deasserted until run
  always_comb begin
    flags_p0.active = 1'b0;
    flags_p0.hsync  = ~H_POL;
    flags_p0.vsync  = ~V_POL;
    if (run) begin
      flags_p0.active = (pos_x < H_VIS) && (pos_y < V_VIS);
      flags_p0.hsync  = in_span(pos_x, HS_START, HS_END) ? H_POL : ~H_POL;
      flags_p0.vsync  = in_span(pos_y, VS_START, VS_END) ? V_POL : ~V_POL;
    end
  end

  // Stage pN: PIPE_DLY (1..4) registers to line up with the renderer output
  sig_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({1'b0, ~H_POL, ~V_POL})
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (flags_p0),
    .dout  (flags_pn)
  );

  assign active = flags_pn.active;
  assign hsync  = flags_pn.hsync;
  assign vsync  = flags_pn.vsync;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, two reduced-size
// instances (delay 1 and 3) for frame, count-wrap and reset scenarios.
module tb_vga_timing;

  localparam int DHT = 1904, DVT = 932;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3, SHT = SHA + SHF + SHS + SHB;
  localparam int SVA = 4, SVF = 1, SVS = 3, SVB = 2, SVT = SVA + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = -1;

  logic [10:0] d_x, d_y, a_x, a_y, b_x, b_y;
  logic [5:0]  d_c, a_c, b_c;
  logic        d_ls, d_fs, d_act, d_hs, d_vs;
  logic        a_ls, a_fs, a_act, a_hs, a_vs;
  logic        b_ls, b_fs, b_act, b_hs, b_vs;

  vga_timing #(.PIPE_DLY(1)) u_def (
    .clk(clk), .rst_n(rst_n), .pos_x(d_x), .pos_y(d_y), .count(d_c),
    .line_start(d_ls), .frame_start(d_fs), .active(d_act), .hsync(d_hs), .vsync(d_vs));

  vga_timing #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
               .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
               .H_POL(1'b0), .V_POL(1'b1), .FRAME_WRAP(60), .PIPE_DLY(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .pos_x(a_x), .pos_y(a_y), .count(a_c),
    .line_start(a_ls), .frame_start(a_fs), .active(a_act), .hsync(a_hs), .vsync(a_vs));

  vga_timing #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
               .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
               .H_POL(1'b0), .V_POL(1'b1), .FRAME_WRAP(60), .PIPE_DLY(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .pos_x(b_x), .pos_y(b_y), .count(b_c),
    .line_start(b_ls), .frame_start(b_fs), .active(b_act), .hsync(b_hs), .vsync(b_vs));

  // Reference model: t counts edges since the post-reset hold edge (t=0).
  function automatic int m_x(int tt, int ht);
    return tt % ht;
  endfunction
  function automatic int m_y(int tt, int ht, int vt);
    return (tt / ht) % vt;
  endfunction
  function automatic int m_c(int tt, int ht, int vt);
    return (tt / (ht * vt)) % 60;
  endfunction
  function automatic logic m_act(int tt, int d, int ht, int vt, int ha, int va);
    if (tt < d) return 1'b0;
    return (m_x(tt - d, ht) < ha) && (m_y(tt - d, ht, vt) < va);
  endfunction
  function automatic logic m_hs(int tt, int d, int ht, int lo, int hi);
    int x;
    if (tt < d) return 1'b1;
    x = m_x(tt - d, ht);
    return !((x >= lo) && (x < hi));
  endfunction
  function automatic logic m_vs(int tt, int d, int ht, int vt, int lo, int hi);
    int y;
    if (tt < d) return 1'b0;
    y = m_y(tt - d, ht, vt);
    return (y >= lo) && (y < hi);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if ({d_x, d_y, d_c} !== 28'd0) begin failures++;
      $display("FAIL reset_counters got x=%0d y=%0d c=%0d exp 0/0/0", d_x, d_y, d_c); end
    checks++; if ({d_ls, d_fs, d_act} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses got ls=%0b fs=%0b act=%0b exp 000", d_ls, d_fs, d_act); end
    checks++; if ({d_hs, d_vs} !== 2'b10) begin failures++;
      $display("FAIL reset_sync got hs=%0b vs=%0b exp hs=1 vs=0", d_hs, d_vs); end
    checks++; if ({b_act, b_hs, b_vs} !== 3'b010) begin failures++;
      $display("FAIL reset_sync_dly3 got %b exp 010", {b_act, b_hs, b_vs}); end
    @(negedge clk);
    rst_n = 1'b1;
    t = -1;
    step();
    checks++; if ({d_fs, d_ls, a_fs, b_fs} !== 4'b1111 || d_x !== 11'd0 || d_y !== 11'd0) begin
      failures++;
      $display("FAIL cycle0 got fs=%0b ls=%0b x=%0d y=%0d exp fs=1 ls=1 x=0 y=0", d_fs, d_ls, d_x, d_y); end
    step();
    checks++; if (d_fs !== 1'b0 || d_ls !== 1'b0 || d_x !== 11'd1) begin failures++;
      $display("FAIL cycle1 got fs=%0b ls=%0b x=%0d exp fs=0 ls=0 x=1", d_fs, d_ls, d_x); end
  endtask

  task automatic test_line_timing();
    int ls_cnt = 0, low_cnt = 0, first_low = -1;
    while (t < DHT + 60) begin
      step();
      checks++; if (d_x !== 11'(m_x(t, DHT)) || d_y !== 11'(m_y(t, DHT, DVT))) begin failures++;
        $display("FAIL line_pos t=%0d got x=%0d y=%0d exp x=%0d y=%0d", t, d_x, d_y,
                 m_x(t, DHT), m_y(t, DHT, DVT)); end
      checks++; if (d_hs !== m_hs(t, 1, DHT, 1520, 1672)) begin failures++;
        $display("FAIL line_hsync t=%0d got %0b exp %0b", t, d_hs, m_hs(t, 1, DHT, 1520, 1672)); end
      if (t <= DHT) begin
        if (d_ls) ls_cnt++;
        if (!d_hs) begin
          if (first_low < 0) first_low = int'(d_x);
          low_cnt++;
        end
      end
    end
    checks++; if (ls_cnt != 1) begin failures++;
      $display("FAIL line_start_count got %0d exp 1", ls_cnt); end
    checks++; if (low_cnt != 152) begin failures++;
      $display("FAIL hsync_width got %0d exp 152", low_cnt); end
    checks++; if (first_low != 1521) begin failures++;
      $display("FAIL hsync_start_x got %0d exp 1521", first_low); end
  endtask

  task automatic test_frame_timing();
    int vs_hi = 0, act_hi = 0, rise_x = -1, rise_y = -1;
    logic prev;
    while (m_x(t, SHT) != 0 || m_y(t, SHT, SVT) != 0) step();
    checks++; if (a_fs !== 1'b1) begin failures++;
      $display("FAIL frame_start_s1 t=%0d got %0b exp 1", t, a_fs); end
    prev = a_vs;
    repeat (SFR) begin
      step();
      checks++; if (a_act !== m_act(t, 1, SHT, SVT, SHA, SVA) || a_vs !== m_vs(t, 1, SHT, SVT, 5, 8)) begin
        failures++;
        $display("FAIL frame_flags t=%0d got act=%0b vs=%0b exp act=%0b vs=%0b", t, a_act, a_vs,
                 m_act(t, 1, SHT, SVT, SHA, SVA), m_vs(t, 1, SHT, SVT, 5, 8)); end
      if (a_vs) vs_hi++;
      if (a_act) act_hi++;
      if (a_vs && !prev && rise_x < 0) begin rise_x = int'(a_x); rise_y = int'(a_y); end
      prev = a_vs;
    end
    checks++; if (vs_hi != SVS * SHT) begin failures++;
      $display("FAIL vsync_width got %0d exp %0d", vs_hi, SVS * SHT); end
    checks++; if (act_hi != SVA * SHA) begin failures++;
      $display("FAIL active_count got %0d exp %0d", act_hi, SVA * SHA); end
    checks++; if (rise_y != SVA + SVF || rise_x != 1) begin failures++;
      $display("FAIL vsync_start got x=%0d y=%0d exp x=1 y=%0d", rise_x, rise_y, SVA + SVF); end
  endtask

  task automatic test_count_wrap();
    int target = t + 61 * SFR;
    int changes = 0, wraps = 0;
    logic [5:0] prev_c = a_c;
    while (t < target) begin
      step();
      checks++; if (a_c !== 6'(m_c(t, SHT, SVT)) || b_c !== a_c) begin failures++;
        $display("FAIL count t=%0d got s1=%0d s3=%0d exp %0d", t, a_c, b_c, m_c(t, SHT, SVT)); end
      if (a_c != prev_c) begin
        changes++;
        checks++; if (a_fs !== 1'b1 || a_x !== 11'd0 || a_y !== 11'd0) begin failures++;
          $display("FAIL count_vs_frame_start t=%0d got fs=%0b x=%0d y=%0d exp fs=1 x=0 y=0",
                   t, a_fs, a_x, a_y); end
        if (prev_c == 6'd59 && a_c == 6'd0) wraps++;
      end
      prev_c = a_c;
    end
    checks++; if (changes != 61) begin failures++;
      $display("FAIL count_changes got %0d exp 61", changes); end
    checks++; if (wraps < 1) begin failures++;
      $display("FAIL count_wrap got %0d wraps exp at least 1", wraps); end
  endtask

  task automatic test_pipeline_alignment();
    int t0, rise_dly = -1, falls = 0, bad_falls = 0;
    logic prev;
    while (m_x(t, SHT) != 0 || m_y(t, SHT, SVT) != 0) step();
    t0 = t;
    prev = b_act;
    repeat (SFR) begin
      step();
      checks++; if (b_act !== m_act(t, 3, SHT, SVT, SHA, SVA) || b_hs !== m_hs(t, 3, SHT, 10, 13)) begin
        failures++;
        $display("FAIL dly3_flags t=%0d got act=%0b hs=%0b exp act=%0b hs=%0b", t, b_act, b_hs,
                 m_act(t, 3, SHT, SVT, SHA, SVA), m_hs(t, 3, SHT, 10, 13)); end
      if (b_act && !prev && rise_dly < 0) rise_dly = t - t0;
      if (!b_act && prev) begin
        falls++;
        if (b_x != 11'(SHA + 3)) bad_falls++;
      end
      prev = b_act;
    end
    checks++; if (rise_dly != 3) begin failures++;
      $display("FAIL dly3_rise got %0d exp 3", rise_dly); end
    checks++; if (falls != SVA || bad_falls != 0) begin failures++;
      $display("FAIL dly3_fall got falls=%0d misplaced=%0d exp falls=%0d misplaced=0", falls, bad_falls, SVA); end
  endtask

  task automatic test_mid_frame_reset();
    int target = ((t / (60 * SFR)) + 1) * 60 * SFR + 17 * SFR + int'($urandom_range(SFR - 1));
    while (t < target) step();
    checks++; if (a_c !== 6'd17 || a_x !== 11'(m_x(t, SHT)) || a_y !== 11'(m_y(t, SHT, SVT))) begin
      failures++;
      $display("FAIL pre_reset got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=17", a_x, a_y, a_c,
               m_x(t, SHT), m_y(t, SHT, SVT)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_x, a_y, a_c, a_ls, a_fs, a_act, a_hs, a_vs} !== {28'd0, 5'b00010}) begin failures++;
      $display("FAIL async_reset_s1 got x=%0d y=%0d c=%0d flags=%b exp 0/0/0 flags=00010",
               a_x, a_y, a_c, {a_ls, a_fs, a_act, a_hs, a_vs}); end
    checks++; if ({b_x, b_c, b_act, b_hs, b_vs, d_x, d_hs} !== {17'd0, 3'b010, 11'd0, 1'b1}) begin failures++;
      $display("FAIL async_reset_other got s3 x=%0d c=%0d flags=%b def x=%0d hs=%0b",
               b_x, b_c, {b_act, b_hs, b_vs}, d_x, d_hs); end
    repeat ($urandom_range(1, 5)) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = -1;
    step();
    checks++; if ({a_x, a_y, a_c} !== 28'd0 || a_fs !== 1'b1 || d_fs !== 1'b1) begin failures++;
      $display("FAIL restart got x=%0d y=%0d c=%0d fs=%0b exp 0/0/0 fs=1", a_x, a_y, a_c, a_fs); end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 4; it++) begin
      int n = int'($urandom_range(40, 700));
      repeat (n) begin
        step();
        checks++; if (a_x !== 11'(m_x(t, SHT)) || a_y !== 11'(m_y(t, SHT, SVT)) || a_c !== 6'(m_c(t, SHT, SVT))
                      || a_ls !== (m_x(t, SHT) == 0)
                      || a_fs !== (m_x(t, SHT) == 0 && m_y(t, SHT, SVT) == 0)) begin failures++;
          $display("FAIL rand_s1_counters t=%0d got x=%0d y=%0d c=%0d ls=%0b fs=%0b", t, a_x, a_y, a_c, a_ls, a_fs); end
        checks++; if (a_act !== m_act(t, 1, SHT, SVT, SHA, SVA) || a_hs !== m_hs(t, 1, SHT, 10, 13)
                      || a_vs !== m_vs(t, 1, SHT, SVT, 5, 8)) begin failures++;
          $display("FAIL rand_s1_flags t=%0d got act=%0b hs=%0b vs=%0b", t, a_act, a_hs, a_vs); end
        checks++; if (b_act !== m_act(t, 3, SHT, SVT, SHA, SVA) || b_hs !== m_hs(t, 3, SHT, 10, 13)
                      || b_vs !== m_vs(t, 3, SHT, SVT, 5, 8) || b_x !== a_x) begin failures++;
          $display("FAIL rand_s3_flags t=%0d got act=%0b hs=%0b vs=%0b x=%0d", t, b_act, b_hs, b_vs, b_x); end
        checks++; if (d_x !== 11'(m_x(t, DHT)) || d_act !== m_act(t, 1, DHT, DVT, 1440, 900)
                      || d_hs !== m_hs(t, 1, DHT, 1520, 1672) || d_vs !== 1'b0) begin failures++;
          $display("FAIL rand_def t=%0d got x=%0d act=%0b hs=%0b vs=%0b", t, d_x, d_act, d_hs, d_vs); end
      end
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      checks++; if ({a_x, a_y, a_c, a_ls, a_fs, a_act, a_hs, a_vs} !== {28'd0, 5'b00010}) begin failures++;
        $display("FAIL rand_async_reset got x=%0d y=%0d c=%0d flags=%b", a_x, a_y, a_c,
                 {a_ls, a_fs, a_act, a_hs, a_vs}); end
      repeat ($urandom_range(1, 4)) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      t = -1;
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_count_wrap();
    test_pipeline_alignment();
    test_mid_frame_reset();
    test_random_resets();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
